// File: rtl/mac_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_pipe_if : operand/result handshake bundle for mac_pipe           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mac_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic signed [DATA_W-1:0] c;
  logic        [1:0]        mode;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  result;
  logic                     overflow;

  modport master (
    output in_valid, a, b, c, mode, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, a, b, c, mode, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface
`default_nettype wire

// File: rtl/mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_pipe : two-stage signed multiply/accumulate with valid/ready     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mac_pipe #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter bit SATURATE = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  mac_pipe_if.slave   bus
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_MAC  = 2'b00,
    MODE_ACC  = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_READ = 2'b11
  } mode_e;

  // Stage 1 registers
  logic                     s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [DATA_W-1:0] addend_q, addend_d;
  mode_e                    mode_q, mode_d;

  // Stage 2 / architectural registers
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  result_q, result_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;

  logic                     w_advance;
  logic signed [PROD_W-1:0] w_prod_in;
  logic signed [ACC_W:0]    w_prod_x;
  logic signed [ACC_W:0]    w_addend_x;
  logic signed [ACC_W:0]    w_acc_x;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_sum_ovf;
  logic signed [ACC_W-1:0]  w_sum_fit;

  // A full stage 2 that cannot drain freezes the whole pipe.
  assign w_advance    = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = w_advance;

  // Operands widened before multiplying so the most-negative square is exact.
  assign w_prod_in = PROD_W'(bus.a) * PROD_W'(bus.b);

  assign w_prod_x   = (ACC_W+1)'(prod_q);
  assign w_addend_x = (ACC_W+1)'(addend_q);
  assign w_acc_x    = (ACC_W+1)'(acc_q);

  assign w_sum     = w_prod_x + ((mode_q == MODE_ACC) ? w_acc_x : w_addend_x);
  assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  generate
    if (SATURATE) begin : g_sat
      assign w_sum_fit = w_sum_ovf ? (w_sum[ACC_W] ? C_MIN : C_MAX)
                                   : w_sum[ACC_W-1:0];
    end else begin : g_wrap
      assign w_sum_fit = w_sum[ACC_W-1:0];
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    prod_d     = prod_q;
    addend_d   = addend_q;
    mode_d     = mode_q;
    if (w_advance) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        prod_d   = w_prod_in;
        addend_d = bus.c;
        mode_d   = mode_e'(bus.mode);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (w_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        case (mode_q)
          MODE_MAC: begin
            result_d = w_sum_fit;
            ovf_d    = ovf_q | w_sum_ovf;
          end
          MODE_ACC: begin
            result_d = w_sum_fit;
            acc_d    = w_sum_fit;
            ovf_d    = ovf_q | w_sum_ovf;
          end
          MODE_LOAD: begin
            // LOAD restarts the sticky flag from this operation alone.
            result_d = w_sum_fit;
            acc_d    = w_sum_fit;
            ovf_d    = w_sum_ovf;
          end
          default: begin
            result_d = acc_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      prod_q      <= '0;
      addend_q    <= '0;
      mode_q      <= MODE_MAC;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      prod_q      <= prod_d;
      addend_q    <= addend_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;

endmodule
`default_nettype wire
